// File: rtl/instr_encoder_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_loader_pkg
//  Description : Shared instruction-kind codes, MIPS opcode/funct constants,
//                the NOP word and word-packing helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_encoder_loader_pkg;

    // Descriptor kind codes; 10..15 are illegal
    localparam logic [3:0] KIND_ADD  = 4'd0;
    localparam logic [3:0] KIND_SUB  = 4'd1;
    localparam logic [3:0] KIND_AND  = 4'd2;
    localparam logic [3:0] KIND_OR   = 4'd3;
    localparam logic [3:0] KIND_SLT  = 4'd4;
    localparam logic [3:0] KIND_ADDI = 4'd5;
    localparam logic [3:0] KIND_SLTI = 4'd6;
    localparam logic [3:0] KIND_BEQ  = 4'd7;
    localparam logic [3:0] KIND_LW   = 4'd8;
    localparam logic [3:0] KIND_SW   = 4'd9;

    // Primary opcodes, identical to the ones the control decoder matches on
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // Padding word (sll $0,$0,0)
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Pack an R-type word; shamt is always zero for the supported set
    function automatic logic [31:0] rtype_word(input logic [4:0] rs,
                                               input logic [4:0] rt,
                                               input logic [4:0] rd,
                                               input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

    // Pack an I-type word; the immediate passes through untouched
    function automatic logic [31:0] itype_word(input logic [5:0]  op,
                                               input logic [4:0]  rs,
                                               input logic [4:0]  rt,
                                               input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_loader_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_word_encoder
//  Description : Combinational descriptor -> 32-bit MIPS word encoder with an
//                illegal-kind flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_word_encoder
    import instr_encoder_loader_pkg::*;
(
    input  logic [3:0]  kind_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    // Select the encoding for the requested kind; unused fields are dropped
    always_comb begin
        word_o    = NOP_WORD;
        illegal_o = 1'b0;
        case (kind_i)
            KIND_ADD:  word_o = rtype_word(rs_i, rt_i, rd_i, FUNCT_ADD);
            KIND_SUB:  word_o = rtype_word(rs_i, rt_i, rd_i, FUNCT_SUB);
            KIND_AND:  word_o = rtype_word(rs_i, rt_i, rd_i, FUNCT_AND);
            KIND_OR:   word_o = rtype_word(rs_i, rt_i, rd_i, FUNCT_OR);
            KIND_SLT:  word_o = rtype_word(rs_i, rt_i, rd_i, FUNCT_SLT);
            KIND_ADDI: word_o = itype_word(OP_ADDI, rs_i, rt_i, imm_i);
            KIND_SLTI: word_o = itype_word(OP_SLTI, rs_i, rt_i, imm_i);
            KIND_BEQ:  word_o = itype_word(OP_BEQ,  rs_i, rt_i, imm_i);
            KIND_LW:   word_o = itype_word(OP_LW,   rs_i, rt_i, imm_i);
            KIND_SW:   word_o = itype_word(OP_SW,   rs_i, rt_i, imm_i);
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_loader
//  Description : Streams instruction descriptors, encodes them and writes them
//                into instruction memory, pads with NOPs, then releases the CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
    parameter int unsigned DEPTH     = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned PAD_NOPS  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        in_last_i,
    input  logic [3:0]  kind_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    output logic        im_we_o,
    output logic [31:0] im_addr_o,
    output logic [31:0] im_data_o,
    output logic [7:0]  count_o,
    output logic        cpu_rst_n_o,
    output logic        done_o,
    output logic        err_illegal_o,
    output logic        err_ovf_o
);
    import instr_encoder_loader_pkg::*;

    // Counter is 8 bits wide to match count_o, so DEPTH must not exceed 255
    localparam logic [7:0] DEPTH_C = 8'(DEPTH);
    localparam logic [7:0] PAD_C   = 8'(PAD_NOPS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_PAD  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [7:0]  pad_q,   pad_d;
    logic        we_q,    we_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] data_q,  data_d;
    logic        ill_q,   ill_d;
    logic        ovf_q,   ovf_d;
    logic        done_q,  done_d;

    logic [31:0] w_enc_word;
    logic        w_enc_illegal;
    logic        w_full;
    logic        w_accept;
    logic        w_pad_more;
    logic [31:0] w_wr_addr;

    instr_word_encoder u_encoder (
        .kind_i    (kind_i),
        .rs_i      (rs_i),
        .rt_i      (rt_i),
        .rd_i      (rd_i),
        .imm_i     (imm_i),
        .word_o    (w_enc_word),
        .illegal_o (w_enc_illegal)
    );

    assign w_full     = (count_q == DEPTH_C);
    assign in_ready_o = (state_q == S_LOAD) && !w_full;
    assign w_accept   = in_valid_i && in_ready_o;
    assign w_pad_more = (pad_q < PAD_C) && !w_full;
    // Address uses the pre-increment counter value
    assign w_wr_addr  = BASE_ADDR + {22'b0, count_q, 2'b00};

    // Next-state logic: session control, write generation and sticky errors
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pad_d   = pad_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        ill_d   = ill_q;
        ovf_d   = ovf_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    count_d = 8'd0;
                    pad_d   = 8'd0;
                    ill_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    // Illegal descriptors are consumed but never written
                    if (w_enc_illegal) begin
                        ill_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = w_wr_addr;
                        data_d  = w_enc_word;
                        count_d = count_q + 8'd1;
                    end
                    if (in_last_i) begin
                        state_d = S_PAD;
                    end
                end else if (in_valid_i && w_full) begin
                    // Full: stay here forever, the CPU is never released
                    ovf_d = 1'b1;
                end
            end
            S_PAD: begin
                if (w_pad_more) begin
                    we_d    = 1'b1;
                    addr_d  = w_wr_addr;
                    data_d  = NOP_WORD;
                    count_d = count_q + 8'd1;
                    pad_d   = pad_q + 8'd1;
                end else begin
                    // Release only after the final write has landed
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset returns everything to zero
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            count_q <= 8'd0;
            pad_q   <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            ill_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pad_q   <= pad_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ill_q   <= ill_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign im_we_o       = we_q;
    assign im_addr_o     = addr_q;
    assign im_data_o     = data_q;
    assign count_o       = count_q;
    assign cpu_rst_n_o   = done_q;
    assign done_o        = done_q;
    assign err_illegal_o = ill_q;
    assign err_ovf_o     = ovf_q;

endmodule
`default_nettype wire

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the control decoder path. Accepts symbolic instruction descriptors (kind, register fields, immediate) over a valid/ready stream.
- Encodes each descriptor into a 32-bit MIPS word and writes it sequentially into instruction memory.
- Pads the program tail with NOPs, then releases the pipelined CPU from its hold-in-reset.
- Sits between the testbench/boot source and the instruction memory write port.

Parameters:
- DEPTH, 128, instruction-memory capacity in words; the write counter saturates here.
- BASE_ADDR, 32'h0, byte address of the first written word.
- PAD_NOPS, 4, number of 32'h0 words appended after the last instruction.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- start_i  in  1  begin a load session; sampled in IDLE only
- in_valid_i  in  1  descriptor valid
- in_ready_o  out  1  descriptor accepted when valid&ready
- in_last_i  in  1  descriptor is the final program instruction
- kind_i  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 ADDI, 6 SLTI, 7 BEQ, 8 LW, 9 SW; 10-15 illegal
- rs_i  in  5  source register
- rt_i  in  5  second source / I-type destination
- rd_i  in  5  R-type destination
- imm_i  in  16  immediate / branch offset, passed through unmodified
- im_we_o  out  1  instruction memory write strobe
- im_addr_o  out  32  byte address
- im_data_o  out  32  encoded word
- count_o  out  8  words written this session
- cpu_rst_n_o  out  1  CPU reset; low holds the CPU
- done_o  out  1  load complete
- err_illegal_o  out  1  sticky: illegal kind seen
- err_ovf_o  out  1  sticky: valid presented while full

Behaviour:
- Reset (async, rst_i=0) drives every output low. State=IDLE, counter=0, sticky errors cleared. In-flight words are lost. A reset mid-session puts the CPU back in reset.
- FSM states IDLE, LOAD, PAD, DONE.
  - IDLE: start_i=1 -> LOAD, counter=0, errors cleared.
  - LOAD: accept descriptors. An accepted descriptor with in_last_i=1 -> PAD.
  - PAD: write one NOP (32'h0) per cycle, PAD_NOPS times or until counter==DEPTH, then -> DONE.
  - DONE: cpu_rst_n_o=1 and done_o=1, both held until reset. start_i is ignored in LOAD, PAD and DONE.
- in_ready_o = (state==LOAD) && (counter<DEPTH).
- Write timing:
  - Latency 1: the descriptor accepted at edge N produces im_we_o=1 for exactly one cycle after edge N.
  - im_addr_o = BASE_ADDR + 4*counter (pre-increment value). Counter increments at the same edge.
  - Sustained throughput is 1 word/cycle.
- Encoding:
  - R-type = {6'b000000, rs, rt, rd, 5'b0, funct}, with funct ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, SLT 6'h2A.
  - I-type = {op, rs, rt, imm}, with op ADDI 6'b001000, SLTI 6'b001010, BEQ 6'b000100, LW 6'b100011, SW 6'b101011.
  - Unused fields are ignored.
- Illegal kind: the descriptor is accepted (ready unaffected), nothing is written, counter is unchanged and err_illegal_o is set. If in_last_i is also set, the FSM still transitions to PAD.
- Full (counter==DEPTH in LOAD):
  - Ready stays low.
  - in_valid_i=1 sets err_ovf_o.
  - The FSM stays in LOAD until reset. The CPU is never released on overflow.
- im_data_o and im_addr_o are don't-care when im_we_o=0. They hold their last value.
- count_o reflects the counter, which saturates at DEPTH.

Decomposition:
- Shared package holds:
  - kind enum constants;
  - opcode constants for R/ADDI/SLTI/BEQ/LW/SW (identical to those used by the control decoder);
  - funct constants;
  - the NOP constant.
- One sub-module, instr_word_encoder: combinational (kind, rs, rt, rd, imm) -> (word, illegal). The top level holds the FSM, counter and output registers.

Test Plan:
- Reset, start, ADD rs=1 rt=2 rd=3 with last=1 -> im_we_o one cycle later, addr 0x0, data 0x00221820. Then 4 NOP writes at 0x4..0x10, then done_o=1 and cpu_rst_n_o=1 with count_o=5.
- Back-to-back ADDI(1,2,imm 5), LW(0,4,imm 8), BEQ(1,2,imm 0xFFFF) on consecutive cycles -> data 0x20220005, 0x8C040008, 0x1022FFFF at 0x0, 0x4, 0x8 on consecutive cycles.
- kind=12 between two ADDs -> err_illegal_o=1. Only 2 words are written, at 0x0 and 0x4, and the counter skips nothing.
- DEPTH=4, stream 6 valid descriptors -> 4 written, in_ready_o=0 afterwards, err_ovf_o=1, cpu_rst_n_o stays 0.
- DEPTH=4, last=1 on the 3rd word -> only 1 NOP is written (saturates at 4), then DONE.
- Assert rst_i=0 during PAD -> all outputs 0 immediately. After release, start_i restarts from addr BASE_ADDR.
